// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions for the jk_reg_bank codebase slice.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_HOLD: r = q;
            JK_RST:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TGL:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK channel: state bit plus a one-cycle flag marking that the bit changed.
module jk_cell
    import jk_pkg::*;
#(
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic changed
);

    logic q_r;
    logic changed_r;
    logic q_next_s;

    // Next-state selection: clear beats enable, enable gates the JK function.
    always_comb begin
        q_next_s = q_r;
        if (clr) begin
            q_next_s = rst_val;
        end else if (!en) begin
            q_next_s = q_r;
        end else begin
            q_next_s = jk_next(q_r, j, k);
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            // State and change flag on the falling edge.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    q_r       <= rst_val;
                    changed_r <= 1'b0;
                end else begin
                    q_r       <= q_next_s;
                    changed_r <= q_next_s ^ q_r;
                end
            end
        end else begin : g_pos
            // State and change flag on the rising edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r       <= rst_val;
                    changed_r <= 1'b0;
                end else begin
                    q_r       <= q_next_s;
                    changed_r <= q_next_s ^ q_r;
                end
            end
        end
    endgenerate

    assign q       = q_r;
    assign changed = changed_r;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK channels with enable, clear-to-value, change flags and a
// saturating count of edges at which any bit changed.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               NEG_EDGE  = 1'b1,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] changed,
    output logic             any_changed,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next_s;
    logic             chg_evt_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             any_r;
    logic             sat_r;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(.NEG_EDGE(NEG_EDGE)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr     (clr),
            .rst_val (RESET_VAL[gi]),
            .j       (j[gi]),
            .k       (k[gi]),
            .q       (q[gi]),
            .changed (changed[gi])
        );
    end

    // Bank-level view of the next state, used only to detect a change event.
    always_comb begin
        q_next_s = q;
        if (clr) begin
            q_next_s = RESET_VAL;
        end else if (!en) begin
            q_next_s = q;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                q_next_s[i] = jk_next(q[i], j[i], k[i]);
            end
        end
        chg_evt_s = |(q_next_s ^ q);
    end

    // Event counter: cnt_clr wins and swallows a coincident event; never wraps.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (chg_evt_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            // Counter and summary flags on the falling edge.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r <= {CNT_W{1'b0}};
                    any_r <= 1'b0;
                    sat_r <= 1'b0;
                end else begin
                    cnt_r <= cnt_next_s;
                    any_r <= chg_evt_s;
                    sat_r <= (cnt_next_s == CNT_MAX);
                end
            end
        end else begin : g_pos
            // Counter and summary flags on the rising edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r <= {CNT_W{1'b0}};
                    any_r <= 1'b0;
                    sat_r <= 1'b0;
                end else begin
                    cnt_r <= cnt_next_s;
                    any_r <= chg_evt_s;
                    sat_r <= (cnt_next_s == CNT_MAX);
                end
            end
        end
    endgenerate

    assign chg_cnt     = cnt_r;
    assign any_changed = any_r;
    assign cnt_sat     = sat_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Drives a rising-edge and a falling-edge jk_reg_bank with identical stimulus
// and compares both against one behavioural model.
module tb_jk_reg_bank;

    localparam logic [3:0] RV  = 4'b1010;
    localparam int         MAXC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, clr = 1'b0, cnt_clr = 1'b0;
    logic [3:0] j = 4'b0000, k = 4'b0000;

    logic [3:0] qn, chn, qp, chp;
    logic       anyn, anyp, satn, satp;
    logic [1:0] cntn, cntp;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_q;
    logic [3:0] m_chg;
    int         m_cnt;

    always #5 clk = ~clk;

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(RV), .NEG_EDGE(1'b1), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .cnt_clr(cnt_clr),
        .q(qn), .changed(chn), .any_changed(anyn), .chg_cnt(cntn), .cnt_sat(satn));

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(RV), .NEG_EDGE(1'b0), .CNT_W(2)) dut_p (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .cnt_clr(cnt_clr),
        .q(qp), .changed(chp), .any_changed(anyp), .chg_cnt(cntp), .cnt_sat(satp));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag, input logic [3:0] q, input logic [3:0] ch,
                            input logic any, input logic [1:0] cnt, input logic sat);
        chk({tag, ".q"}, {28'd0, q}, {28'd0, m_q});
        chk({tag, ".changed"}, {28'd0, ch}, {28'd0, m_chg});
        chk({tag, ".any"}, {31'd0, any}, {31'd0, (m_chg != 4'b0000)});
        chk({tag, ".cnt"}, {30'd0, cnt}, m_cnt);
        chk({tag, ".sat"}, {31'd0, sat}, {31'd0, (m_cnt == MAXC)});
    endtask

    task automatic model_reset();
        m_q = RV;
        m_chg = 4'b0000;
        m_cnt = 0;
    endtask

    // One evaluation: inputs held over a rising edge (dut_p) then a falling edge (dut_n).
    task automatic step(input logic [3:0] tj, input logic [3:0] tk, input logic ten,
                        input logic tclr, input logic tcc);
        logic [3:0] nq;
        logic [3:0] old_q;
        j = tj; k = tk; en = ten; clr = tclr; cnt_clr = tcc;
        old_q = m_q;
        for (int i = 0; i < 4; i++) begin
            if (tclr)                  nq[i] = RV[i];
            else if (!ten)             nq[i] = m_q[i];
            else if (tj[i] && tk[i])   nq[i] = !m_q[i];
            else if (tj[i])            nq[i] = 1'b1;
            else if (tk[i])            nq[i] = 1'b0;
            else                       nq[i] = m_q[i];
        end
        m_chg = nq ^ m_q;
        if (tcc)                                 m_cnt = 0;
        else if (m_chg != 4'b0000 && m_cnt < MAXC) m_cnt = m_cnt + 1;
        m_q = nq;
        @(posedge clk); #1;
        chk_bank("pos", qp, chp, anyp, cntp, satp);
        chk("neg_hold_at_rise", {28'd0, qn}, {28'd0, old_q});
        @(negedge clk); #1;
        chk_bank("neg", qn, chn, anyn, cntn, satn);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk_bank("rst_pos", qp, chp, anyp, cntp, satp);
        chk_bank("rst_neg", qn, chn, anyn, cntn, satn);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rj, rk;
        model_reset();
        @(negedge clk); #1;
        // reset asserted between edges and held across both edge types
        rst = 1'b1; #1;
        chk_bank("reset_pos", qp, chp, anyp, cntp, satp);
        chk_bank("reset_neg", qn, chn, anyn, cntn, satn);
        j = 4'b1111; k = 4'b0000; en = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk_bank("reset_hold_pos", qp, chp, anyp, cntp, satp);
        chk_bank("reset_hold_neg", qn, chn, anyn, cntn, satn);
        rst = 1'b0; #1;
        // clear to 0000 with a coincident cnt_clr: change flagged, not counted
        step(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
        chk("cntclr_changed", {28'd0, chn}, 32'h0000000a);
        // JK truth table
        step(4'b1100, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("tt1_q", {28'd0, qn}, 32'h0000000c);
        step(4'b1100, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("tt2_q", {28'd0, qn}, 32'h00000008);
        chk("tt2_cnt", {30'd0, cntn}, 32'd2);
        // enable low holds everything
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        // clear priority from 0101
        step(4'b0101, 4'b1010, 1'b1, 1'b0, 1'b1);
        step(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
        chk("clr_changed", {28'd0, chn}, 32'h0000000f);
        // saturation: toggle bit0 five times after counter clear
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", {30'd0, cntn}, 32'd3);
        // randomized traffic with occasional mid-operation reset
        for (int n = 0; n < 300; n++) begin
            rj = 4'($urandom);
            rk = 4'($urandom);
            if ($urandom_range(0, 39) == 0) pulse_reset();
            step(rj, rk, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 11) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
